// File: rtl/v_hier_sub_arb.sv
// Round-robin arbiter that time-shares one v_hier_sub datapath among NREQ requesters.
// A granted operand goes out on avec, qvec is sampled after the settle delay, and the result is acked.
module v_hier_sub_arb #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic [1:0]        rsp_data,
    output logic              rsp_valid,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic [1:0]        avec,
    input  logic [1:0]        qvec
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic [IDW-1:0] LastInit = IDW'(NREQ - 1);
    localparam logic [3:0]     CntInit  = 4'(WAIT_CYC);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [1:0]      avec_q, avec_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [1:0]      rsp_data_q, rsp_data_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic [1:0]      req_op [NREQ];
    logic            found;
    logic [IDW-1:0]  pick;
    int unsigned     idx;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            req_op[i] = req_data[2*i +: 2];
        end
    end

    // Search starts one past the last grant so the previous winner has lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_q) + k) % NREQ;
            if (!found && req[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        grant_d     = grant_q;
        avec_d      = avec_q;
        ack_d       = '0;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    last_d  = pick;
                    avec_d  = req_op[pick];
                    cnt_d   = CntInit;
                    state_d = StWait;
                end
            end
            StWait: begin
                // The grant is committed; req is no longer looked at here.
                if (cnt_q == 4'd0) begin
                    rsp_data_d     = qvec;
                    rsp_valid_d    = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    state_d        = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            last_q      <= LastInit;
            grant_q     <= '0;
            avec_q      <= 2'b00;
            ack_q       <= '0;
            rsp_data_q  <= 2'b00;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            avec_q      <= avec_d;
            ack_q       <= ack_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign ack       = ack_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;
    assign grant_id  = grant_q;
    assign avec      = avec_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_v_hier_sub_arb.sv
// Directed bench for v_hier_sub_arb: scoreboarded acks on the WAIT_CYC=1 instance,
// plus latency/sampling checks on WAIT_CYC=0 and WAIT_CYC=15 instances.
module tb_v_hier_sub_arb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: WAIT_CYC=1, sub model qvec = avec
    logic [3:0] req_a, ack_a;
    logic [7:0] req_data_a;
    logic [1:0] rsp_a, grant_a, avec_a, qvec_a;
    logic       rsp_valid_a, busy_a;
    assign qvec_a = avec_a;

    // Instances B (WAIT_CYC=0) and C (WAIT_CYC=15): qvec driven by the bench
    logic [3:0] req_b, ack_b, req_c, ack_c;
    logic [7:0] req_data_b, req_data_c;
    logic [1:0] rsp_b, grant_b, avec_b, qvec_b, rsp_c, grant_c, avec_c, qvec_c;
    logic       rsp_valid_b, busy_b, rsp_valid_c, busy_c;

    v_hier_sub_arb #(.NREQ(4), .IDW(2), .WAIT_CYC(1)) u_dut_a (
        .clk(clk), .reset(reset), .req(req_a), .req_data(req_data_a), .ack(ack_a),
        .rsp_data(rsp_a), .rsp_valid(rsp_valid_a), .grant_id(grant_a), .busy(busy_a),
        .avec(avec_a), .qvec(qvec_a)
    );
    v_hier_sub_arb #(.NREQ(4), .IDW(2), .WAIT_CYC(0)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .req_data(req_data_b), .ack(ack_b),
        .rsp_data(rsp_b), .rsp_valid(rsp_valid_b), .grant_id(grant_b), .busy(busy_b),
        .avec(avec_b), .qvec(qvec_b)
    );
    v_hier_sub_arb #(.NREQ(4), .IDW(2), .WAIT_CYC(15)) u_dut_c (
        .clk(clk), .reset(reset), .req(req_c), .req_data(req_data_c), .ack(ack_c),
        .rsp_data(rsp_c), .rsp_valid(rsp_valid_c), .grant_id(grant_c), .busy(busy_c),
        .avec(avec_c), .qvec(qvec_c)
    );

    typedef struct {
        logic [1:0] id;
        logic [1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] id, input logic [1:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        return e;
    endfunction

    // One clock; sample #1 after the edge and score any ack from instance A.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        chk("valid_eq_ack", {31'd0, rsp_valid_a}, {31'd0, |ack_a});
        if (ack_a != 4'b0000) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", {28'd0, ack_a}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_onehot", {28'd0, ack_a}, 32'd1 << e.id);
                chk("rsp_data", {30'd0, rsp_a}, {30'd0, e.data});
                chk("ack_grant_id", {30'd0, grant_a}, {30'd0, e.id});
            end
        end
    endtask

    task automatic wait_ack(output int at);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack_a == 4'b0000 && n < 40);
        if (ack_a == 4'b0000) chk("ack_timeout", {28'd0, ack_a}, 32'd1);
        at = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int   t_prev, t_now;
    exp_t order[5];

    initial begin
        reset = 1'b1;
        req_a = '0; req_b = '0; req_c = '0;
        req_data_a = '0; req_data_b = '0; req_data_c = '0;
        qvec_b = '0; qvec_c = '0;
        #2;
        chk("rst_ack", {28'd0, ack_a}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid_a}, 32'd0);
        chk("rst_rsp", {30'd0, rsp_a}, 32'd0);
        chk("rst_avec", {30'd0, avec_a}, 32'd0);
        chk("rst_grant", {30'd0, grant_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        tick();
        reset = 1'b0;

        // Single request, requester 0 has first priority after reset
        req_data_a = 8'b00_00_00_10;
        req_a      = 4'b0001;
        sb.push_back(mk(2'd0, 2'b10));
        tick();
        chk("t1_avec_e1", {30'd0, avec_a}, 32'b10);
        chk("t1_grant_e1", {30'd0, grant_a}, 32'd0);
        chk("t1_busy_e1", {31'd0, busy_a}, 32'd1);
        chk("t1_ack_e1", {28'd0, ack_a}, 32'd0);
        tick();
        chk("t1_ack_e2", {28'd0, ack_a}, 32'd0);
        tick();
        chk("t1_ack_e3", {28'd0, ack_a}, 32'b0001);
        req_a = 4'b0000;
        tick();
        chk("t1_valid_e4", {31'd0, rsp_valid_a}, 32'd0);
        chk("t1_busy_e4", {31'd0, busy_a}, 32'd0);
        req_data_a = 8'hFF;
        tick();
        tick();
        chk("t1_avec_hold", {30'd0, avec_a}, 32'b10);

        // All requesters held from reset: order 0,1,2,3,0, acks 4 cycles apart
        req_data_a = 8'b00_11_10_01;
        req_a      = 4'b1111;
        order[0] = mk(2'd0, 2'b01); order[1] = mk(2'd1, 2'b10);
        order[2] = mk(2'd2, 2'b11); order[3] = mk(2'd3, 2'b00);
        order[4] = mk(2'd0, 2'b01);
        for (int k = 0; k < 5; k++) sb.push_back(order[k]);
        do_reset();
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ack(t_now);
            if (k > 0) chk("rr_spacing", t_now - t_prev, 32'd4);
            t_prev = t_now;
        end
        req_a = 4'b0000;
        tick();
        tick();
        chk("rr_drained", sb.size(), 32'd0);

        // RR skip: grant 1 first, then req=1001 must go 3 then 0
        do_reset();
        req_data_a = 8'b10_01_11_00;
        req_a      = 4'b0010;
        sb.push_back(mk(2'd1, 2'b11));
        wait_ack(t_now);
        req_a = 4'b1001;
        sb.push_back(mk(2'd3, 2'b10));
        sb.push_back(mk(2'd0, 2'b00));
        tick();
        tick();
        chk("skip_grant3", {30'd0, grant_a}, 32'd3);
        wait_ack(t_now);
        req_a = 4'b0001;
        wait_ack(t_now);
        req_a = 4'b0000;
        tick();
        chk("skip_drained", sb.size(), 32'd0);

        // Reset mid-WAIT aborts; requester 2 is re-granted afterwards
        req_data_a = 8'b00_01_00_00;
        req_a      = 4'b0100;
        sb.push_back(mk(2'd2, 2'b01));
        tick();
        chk("rw_busy", {31'd0, busy_a}, 32'd1);
        chk("rw_grant", {30'd0, grant_a}, 32'd2);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("rw_ack", {28'd0, ack_a}, 32'd0);
        chk("rw_valid", {31'd0, rsp_valid_a}, 32'd0);
        chk("rw_avec", {30'd0, avec_a}, 32'd0);
        chk("rw_grant0", {30'd0, grant_a}, 32'd0);
        chk("rw_busy0", {31'd0, busy_a}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        sb.push_back(mk(2'd2, 2'b01));
        wait_ack(t_now);
        req_a = 4'b0000;
        tick();
        chk("rw_drained", sb.size(), 32'd0);

        // Early req drop: grant committed, one ack, busy through WAIT/DONE
        req_data_a = 8'b00_00_11_00;
        req_a      = 4'b0010;
        sb.push_back(mk(2'd1, 2'b11));
        tick();
        req_a = 4'b0000;
        chk("ed_busy_w0", {31'd0, busy_a}, 32'd1);
        tick();
        chk("ed_busy_w1", {31'd0, busy_a}, 32'd1);
        tick();
        chk("ed_ack", {28'd0, ack_a}, 32'b0010);
        chk("ed_busy_done", {31'd0, busy_a}, 32'd1);
        tick();
        chk("ed_busy_idle", {31'd0, busy_a}, 32'd0);
        tick();
        tick();
        chk("ed_drained", sb.size(), 32'd0);

        // WAIT_CYC=0: ack after 2 edges, qvec sampled on first WAIT edge
        req_data_b = 8'b00_00_00_11;
        req_b      = 4'b0001;
        qvec_b     = 2'b00;
        tick();
        chk("w0_ack_e1", {28'd0, ack_b}, 32'd0);
        chk("w0_avec", {30'd0, avec_b}, 32'b11);
        qvec_b = 2'b10;
        tick();
        chk("w0_ack_e2", {28'd0, ack_b}, 32'b0001);
        chk("w0_rsp", {30'd0, rsp_b}, 32'b10);
        chk("w0_valid", {31'd0, rsp_valid_b}, 32'd1);
        req_b  = 4'b0000;
        qvec_b = 2'b01;
        tick();
        chk("w0_valid_off", {31'd0, rsp_valid_b}, 32'd0);

        // WAIT_CYC=15: ack after 17 edges, earlier qvec values ignored
        req_data_c = 8'b00_00_01_00;
        req_c      = 4'b0010;
        qvec_c     = 2'b00;
        tick();
        chk("w15_grant", {30'd0, grant_c}, 32'd1);
        chk("w15_avec", {30'd0, avec_c}, 32'b01);
        req_c = 4'b0000;
        for (int e = 2; e <= 16; e++) begin
            qvec_c = 2'($urandom_range(0, 2));
            tick();
            chk("w15_no_early_ack", {28'd0, ack_c}, 32'd0);
        end
        qvec_c = 2'b11;
        tick();
        chk("w15_ack_e17", {28'd0, ack_c}, 32'b0010);
        chk("w15_rsp", {30'd0, rsp_c}, 32'b11);
        qvec_c = 2'b00;
        tick();
        chk("w15_ack_off", {28'd0, ack_c}, 32'd0);
        chk("w15_rsp_hold", {30'd0, rsp_c}, 32'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
